// File: rtl/wma_filter_mac.sv
// wma_filter_mac: weighted-moving-average filter built around one time-shared MAC.
// Each accepted sample shifts the delay line. The MAC then walks all TAPS weights,
// one tap per cycle, and the sum is normalised by a reciprocal multiply with
// rounding and saturation.
// Optional feature macro: WMA_COEF_PROG_EN adds run-time programmable weights
// through the coef_* ports. Without it the weights are the constants w[k]=TAPS-k.
module wma_filter_mac #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TAPS       = 8,
  parameter int unsigned COEF_W     = 8,
  parameter int unsigned NORM_MUL   = 1820,
  parameter int unsigned NORM_SHIFT = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        Xn,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        Yn
`ifdef WMA_COEF_PROG_EN
  ,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data
`endif
);

  localparam int unsigned AW     = $clog2(TAPS);
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + AW;
  localparam int unsigned NORM_W = ACC_W + 32;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_NORM} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   x_q [TAPS];
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [AW-1:0]       k_q, k_d;
  logic [DATA_W-1:0]   yn_q;
  logic                out_valid_q;
  logic [COEF_W-1:0]   w [TAPS];
  logic [PROD_W-1:0]   prod;
  logic [NORM_W-1:0]   norm_full;
  logic [DATA_W-1:0]   norm_sat;
  logic                accept;

  // A clear in the same cycle wins over an incoming sample.
  assign accept    = in_valid && (state_q == S_IDLE) && !clr;
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign Yn        = yn_q;

`ifdef WMA_COEF_PROG_EN
  logic [COEF_W-1:0] w_q [TAPS];

  // Weight registers: writable only in IDLE so one computation sees a stable set.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < TAPS; k++) w_q[k] <= COEF_W'(TAPS - k);
    end else if (coef_we && (state_q == S_IDLE)) begin
      // The address decode only matches 0..TAPS-1, so out-of-range writes drop out.
      for (int k = 0; k < TAPS; k++) begin
        if (coef_addr == AW'(k)) w_q[k] <= coef_data;
      end
    end
  end

  // Expose the programmed weights to the MAC.
  always_comb begin
    for (int k = 0; k < TAPS; k++) w[k] = w_q[k];
  end
`else
  // Fixed linearly decaying weights; the newest sample carries the largest weight.
  always_comb begin
    for (int k = 0; k < TAPS; k++) w[k] = COEF_W'(TAPS - k);
  end
`endif

  // Product of the current tap. Operands are widened first so no bits are lost.
  assign prod = {{DATA_W{1'b0}}, w[k_q]} * {{COEF_W{1'b0}}, x_q[k_q]};

  // Reciprocal-multiply normalisation with round-half-up, then clamp to full scale.
  assign norm_full = ({32'b0, acc_q} * NORM_W'(NORM_MUL)
                      + (NORM_W'(1) << (NORM_SHIFT - 1))) >> NORM_SHIFT;
  assign norm_sat  = (norm_full > NORM_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}}
                                                           : norm_full[DATA_W-1:0];

  // Next-state logic for the IDLE -> MAC -> NORM sequence.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    acc_d   = acc_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_MAC;
          acc_d   = '0;
          k_d     = '0;
        end
      end
      S_MAC: begin
        acc_d = acc_q + {{AW{1'b0}}, prod};
        k_d   = k_q + AW'(1);
        if (k_q == AW'(TAPS - 1)) state_d = S_NORM;
      end
      S_NORM:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clr) begin
      state_d = S_IDLE;
      acc_d   = '0;
      k_d     = '0;
    end
  end

  // FSM, accumulator and tap-index registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      k_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
    end
  end

  // Delay line: shifts on accept and is zero-filled by reset or clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: this small delay-line array is reset because its zero history is observable.
      for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
    end else if (accept) begin
      x_q[0] <= Xn;
      for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
    end
  end

  // Output register and one-cycle strobe. A clear suppresses the strobe; Yn holds.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      yn_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= (state_q == S_NORM) && !clr;
      if ((state_q == S_NORM) && !clr) yn_q <= norm_sat;
    end
  end

endmodule

// File: tb/tb_wma_filter_mac.sv
// tb_wma_filter_mac: directed and random stimulus for wma_filter_mac.
// A reference model computes each expected output from the sample history and weights.
module tb_wma_filter_mac;

  localparam int DATA_W = 8;
  localparam int TAPS   = 8;
  localparam int COEF_W = 8;
  localparam longint NORM_MUL   = 1820;
  localparam int     NORM_SHIFT = 16;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              clr = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] Xn = '0;
  logic              out_valid;
  logic [DATA_W-1:0] Yn;
`ifdef WMA_COEF_PROG_EN
  logic              coef_we = 1'b0;
  logic [2:0]        coef_addr = '0;
  logic [COEF_W-1:0] coef_data = '0;
`endif

  int     n_checks = 0;
  int     n_fail   = 0;
  longint hist_m [TAPS];
  longint w_m    [TAPS];
  longint exp_y;

  wma_filter_mac #(
    .DATA_W(DATA_W), .TAPS(TAPS), .COEF_W(COEF_W),
    .NORM_MUL(1820), .NORM_SHIFT(NORM_SHIFT)
  ) dut (
    .CLK(CLK), .RST(RST), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .Xn(Xn), .out_valid(out_valid), .Yn(Yn)
`ifdef WMA_COEF_PROG_EN
    , .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      hist_m[k] = 0;
      w_m[k]    = TAPS - k;
    end
  endtask

  // Weighted sum of the window, scaled by NORM_MUL/2^16 with rounding, clamped to 255.
  function automatic longint model_push(input longint x);
    longint sum, y;
    for (int k = TAPS - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
    hist_m[0] = x;
    sum = 0;
    for (int k = 0; k < TAPS; k++) sum += w_m[k] * hist_m[k];
    y = (sum * NORM_MUL + (64'sd1 << (NORM_SHIFT - 1))) >>> NORM_SHIFT;
    if (y > 255) y = 255;
    return y;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offers one sample; returns after the accept edge (edge 0).
  task automatic do_accept(input longint x, input bit hold, input bit expect_immediate);
    int waited = 0;
    while (!in_ready && waited < 30) begin
      tick();
      waited++;
    end
    check("accept_ready", in_ready, 1);
    if (expect_immediate) check("hold_gap", waited, 0);
    Xn       = DATA_W'(x);
    in_valid = 1'b1;
    exp_y    = model_push(x);
    tick();
    if (!hold) in_valid = 1'b0;
    check("ready_low_after_accept", in_ready, 0);
    check("strobe_low_after_accept", out_valid, 0);
  endtask

  // Waits for the strobe, starting `start` edges after the accept edge.
  task automatic await_result(input int start);
    int i = start;
    bit seen = 0;
    while (!seen && i < TAPS + 6) begin
      tick();
      i++;
      if (out_valid) seen = 1;
      else check("ready_low_busy", in_ready, 0);
    end
    check("strobe_seen", seen, 1);
    check("latency", i, TAPS + 1);
    check("yn", Yn, exp_y);
    check("ready_at_strobe", in_ready, 1);
  endtask

  task automatic feed(input longint x);
    do_accept(x, 0, 0);
    await_result(0);
  endtask

  initial begin
    int quiet;
    model_reset();

    // Reset held with random inputs.
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'($urandom);
      clr      = 1'($urandom);
      Xn       = DATA_W'($urandom);
      tick();
      check("rst_yn", Yn, 0);
      check("rst_valid", out_valid, 0);
      check("rst_ready", in_ready, 1);
    end
    in_valid = 0;
    clr      = 0;
    RST      = 1;
    tick();
    tick();
    check("post_rst_yn", Yn, 0);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_ready", in_ready, 1);

    // Impulse response from zero history.
    feed(36);
    check("impulse_first", Yn, 8);
    for (int n = 0; n < TAPS; n++) feed(0);
    check("impulse_tail", Yn, 0);

    // Step response.
    feed(255);
    check("step_first", Yn, 57);
    for (int n = 1; n < TAPS; n++) feed(255);
    check("step_eighth", Yn, 255);
    feed(255);
    check("step_steady", Yn, 255);

    // in_valid held high: back-to-back accepts every TAPS+2 cycles.
    for (int n = 0; n < 5; n++) begin
      do_accept($urandom_range(0, 255), 1, n > 0);
      await_result(0);
    end
    in_valid = 0;
    tick();
    check("hold_strobe_drops", out_valid, 0);

    // Refill with 255, then clear mid-MAC.
    for (int n = 0; n < TAPS; n++) feed(255);
    do_accept(255, 0, 0);
    tick();
    tick();
    clr = 1;
    tick();
    clr = 0;
    check("clr_idle", in_ready, 1);
    quiet = 1;
    for (int c = 0; c < TAPS + 4; c++) begin
      if (out_valid) quiet = 0;
      tick();
    end
    check("clr_no_strobe", quiet, 1);
    check("clr_yn_hold", Yn, 255);
    for (int k = 0; k < TAPS; k++) hist_m[k] = 0;
    // A sample offered together with clr is not taken.
    clr      = 1;
    in_valid = 1;
    Xn       = 8'd99;
    tick();
    clr      = 0;
    in_valid = 0;
    check("clr_blocks_accept", in_ready, 1);
    feed(255);
    check("clr_then_step", Yn, 57);

    // Asynchronous reset mid-computation.
    do_accept(200, 0, 0);
    tick();
    tick();
    RST = 0;
    #1;
    check("midrst_yn", Yn, 0);
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 1);
    tick();
    RST = 1;
    model_reset();
    quiet = 1;
    for (int c = 0; c < TAPS + 4; c++) begin
      tick();
      if (out_valid) quiet = 0;
    end
    check("midrst_no_strobe", quiet, 1);
    feed(255);
    check("midrst_then_step", Yn, 57);

    // Random samples with random idle gaps.
    for (int n = 0; n < 20; n++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      feed($urandom_range(0, 255));
    end

`ifdef WMA_COEF_PROG_EN
    // Programmable weights: single tap of 36.
    for (int k = 0; k < TAPS; k++) begin
      coef_we   = 1;
      coef_addr = 3'(k);
      coef_data = (k == 0) ? 8'd36 : 8'd0;
      w_m[k]    = (k == 0) ? 36 : 0;
      tick();
    end
    coef_we = 0;
    feed(100);
    check("prog_single_tap", Yn, 100);
    // A write during MAC is ignored.
    do_accept(100, 0, 0);
    coef_we   = 1;
    coef_addr = 3'd0;
    coef_data = 8'd0;
    tick();
    coef_we = 0;
    await_result(1);
    check("prog_busy_write_result", Yn, 100);
    feed(100);
    check("prog_busy_write_ignored", Yn, 100);
    // Large weights drive the result into saturation.
    for (int k = 0; k < TAPS; k++) begin
      coef_we   = 1;
      coef_addr = 3'(k);
      coef_data = 8'd255;
      w_m[k]    = 255;
      tick();
    end
    coef_we = 0;
    feed(255);
    check("prog_saturate", Yn, 255);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
